wl_mult_pipe: RTL
=================

Name: wl_mult_pipe

Overview:
- Multi-lane, parametrised fixed-point multiplier with a valid/ready handshake, selectable signed/unsigned arithmetic, a programmable output bit window, and saturation on overflow.
- Successor to the fixed 8-bit, free-running unsigned multiplier used in the canny datapath (gradient magnitude, kernel MACs).
- Lets stalling downstream stages (NMS, hysteresis line buffers) back-pressure the multiplier without losing products.
- Pure RTL; no vendor macro.

Parameters:
- NCH, 1: number of independent multiplier lanes sharing one handshake.
- IW, 8: input operand width per lane.
- OW, 8: output width per lane; 1..2*IW.
- SHIFT, 8: LSB index of the output window within the 2*IW-bit full product; SHIFT+OW <= 2*IW.
- LAT, 3: pipeline depth in cycles, input accept to output valid; 1..4.
- SIGNED, 0: 0 = unsigned operands/result; 1 = two's-complement operands/result.

Ports:
- clk  in  1  rising-edge clock
- rst_b  in  1  asynchronous reset, active-high, despite the name; async assert, sync-to-clk deassert handled upstream
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  NCH*IW  operand A; lane k = bits [k*IW+IW-1 : k*IW]
- in_b  in  NCH*IW  operand B; same lane packing
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_p  out  NCH*OW  result per lane; same packing with OW
- out_ovf  out  NCH  per-lane flag: the result was saturated

Behaviour:
- Reset (rst_b=1, asynchronous):
  - all stage valid bits, out_valid, out_p and out_ovf clear to 0;
  - in_ready reads 1 once reset is released;
  - in-flight beats are discarded, not flushed.
- Pipeline advance:
  - adv = ~out_valid | out_ready; in_ready = adv (combinational).
  - When adv=1, all LAT stages shift one place.
  - Stage-0 valid loads in_valid & in_ready.
  - Data registers load regardless of valid.
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+LAT when out_ready stays high.
- Stall and bubbles:
  - while out_valid=1 and out_ready=0, out_p, out_ovf and out_valid hold and no stage shifts;
  - bubbles are not compressed;
  - full throughput is one beat per cycle when out_ready=1.
- Arithmetic, per lane:
  - the full product P has 2*IW bits;
  - unsigned when SIGNED=0; sign-extended operands when SIGNED=1;
  - exact, with no loss in the product itself.
- Window:
  - W = P >> SHIFT (arithmetic shift if SIGNED), evaluated at 2*IW+1 bits;
  - the result is the low OW bits of W when W fits in OW bits.
- Saturation, when W does not fit:
  - SIGNED=0: all-ones;
  - SIGNED=1: positive overflow gives 0 followed by OW-1 ones; negative overflow gives 1 followed by OW-1 zeros;
  - out_ovf[k]=1 for the beat. Otherwise out_ovf[k]=0.
- Stage placement:
  - multiply at stage 0, or registered operands then multiply when LAT>=2;
  - window and saturation in the final stage;
  - extra stages are pure delay registers.
- Simultaneous events:
  - a new beat accepted in the same cycle the output drains is legal;
  - no beat is lost or duplicated.
- Corner operands:
  - SIGNED=1, (-2^(IW-1)) * (-2^(IW-1)) must yield the correct positive product before windowing.

Optional Feature:
- Macro WL_MULT_ROUND_EN.
- Defined:
  - when SHIFT>0, add 2^(SHIFT-1) to P before the shift (round half up, toward +inf for signed);
  - the addition uses 2*IW+1 bits;
  - a carry that overflows the window saturates as above.
- Undefined: plain truncation (floor); no rounding adder is built.

Decomposition:
- Shared package wl_pkg:
  - lane-slicing helper constants;
  - saturation limit functions sat_max(OW,SIGNED) and sat_min(OW,SIGNED).
- One sub-module: wl_mult_lane (single-lane multiply, round, window, saturate), instantiated NCH times.
- Handshake and valid pipeline stay in wl_mult_pipe.

Test Plan:
- NCH=1, IW=8, OW=8, SHIFT=8, SIGNED=0, LAT=3: a=255, b=255 → P=0xFE01, out_p=0xFE, out_ovf=0, out_valid exactly 3 cycles after accept.
- Same config, a=16, b=8 (P=0x0080) → out_p=0x00 without WL_MULT_ROUND_EN; 0x01 with it.
- SIGNED=1, SHIFT=8: a=0x80, b=0x80 (−128·−128=16384) → out_p=0x40. With SHIFT=0: out_p=0x7F, out_ovf=1. SHIFT=0, a=0x80, b=0x7F → out_p=0x80, out_ovf=1.
- NCH=4, 20-beat random stream, out_ready toggled pseudo-randomly at 50%:
  - every lane matches the reference model in order;
  - no drops or duplicates;
  - out_p stable while stalled.
- Pipeline full (LAT beats in flight), out_ready=0 for 5 cycles → in_ready=0 throughout; release gives back-to-back outputs.
- Assert rst_b mid-stream with 2 beats in flight → out_valid=0 and out_p=0 immediately (asynchronous); after release, no stale beat appears.

Source files
------------

// File: rtl/wl_pkg.sv
// Shared definitions for the wl_mult_pipe multiplier family:
// lane-slicing helper and saturation limits.
package wl_pkg;

    // Widest output window the saturation helpers can describe.
    localparam int WL_MAXW = 64;

    // LSB position of lane k in a bus packed with w bits per lane.
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

    // Largest representable result of an ow-bit window (low ow bits valid).
    function automatic logic [WL_MAXW-1:0] sat_max(input int ow, input int sgn);
        logic [WL_MAXW-1:0] v;
        if (sgn != 32'sd0) begin
            v = (64'd1 << (ow - 32'sd1)) - 64'd1;
        end else begin
            v = (64'd1 << ow) - 64'd1;
        end
        return v;
    endfunction

    // Smallest representable result of an ow-bit window (low ow bits valid).
    function automatic logic [WL_MAXW-1:0] sat_min(input int ow, input int sgn);
        logic [WL_MAXW-1:0] v;
        if (sgn != 32'sd0) begin
            v = 64'd1 << (ow - 32'sd1);
        end else begin
            v = 64'd0;
        end
        return v;
    endfunction

endpackage

// File: rtl/wl_mult_lane.sv
// Single multiplier lane: operand capture, exact 2*IW-bit product,
// optional product delay stages, then window extraction and saturation
// in the final registered stage. Rounding (round half up) is built only
// when WL_MULT_ROUND_EN is defined; otherwise the window truncates.
module wl_mult_lane
    import wl_pkg::*;
#(
    parameter int IW     = 8,
    parameter int OW     = 8,
    parameter int SHIFT  = 8,
    parameter int LAT    = 3,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          i_adv,
    input  logic [IW-1:0] i_a,
    input  logic [IW-1:0] i_b,
    output logic [OW-1:0] o_p,
    output logic          o_ovf
);

    localparam int PW = 2 * IW;
    localparam int EW = PW + 1;
    localparam bit IS_SGN = (SIGNED != 32'sd0);
    localparam logic [OW-1:0] SAT_HI = OW'(sat_max(OW, SIGNED));
    localparam logic [OW-1:0] SAT_LO = OW'(sat_min(OW, SIGNED));
`ifdef WL_MULT_ROUND_EN
    // Half an output LSB; zero when SHIFT is 0 so no rounding happens.
    localparam logic [EW-1:0] RND_K = ({{(EW-1){1'b0}}, 1'b1} << SHIFT) >> 1;
`endif

    logic [IW-1:0] w_op_a;
    logic [IW-1:0] w_op_b;
    logic [PW-1:0] w_ea;
    logic [PW-1:0] w_eb;
    logic [PW-1:0] w_prod;
    logic [PW-1:0] w_pfin;
    logic [EW-1:0] w_pext;
    logic [EW-1:0] w_rnd;
    logic [EW-1:0] w_win;
    logic          w_fit;
    logic [OW-1:0] w_res;
    logic          w_ovf;

    generate
        if (LAT >= 2) begin : g_opreg
            logic [IW-1:0] r_a;
            logic [IW-1:0] r_b;
            // Stage 0: capture operands; multiply happens in the next stage.
            always_ff @(posedge clk or posedge rst_b) begin
                if (rst_b) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (i_adv) begin
                    r_a <= i_a;
                    r_b <= i_b;
                end
            end
            assign w_op_a = r_a;
            assign w_op_b = r_b;
        end else begin : g_opdir
            assign w_op_a = i_a;
            assign w_op_b = i_b;
        end
    endgenerate

    // Exact product: operands widened to 2*IW bits so the low 2*IW bits of
    // the product are correct for both unsigned and two's-complement.
    always_comb begin
        if (IS_SGN) begin
            w_ea = {{IW{w_op_a[IW-1]}}, w_op_a};
            w_eb = {{IW{w_op_b[IW-1]}}, w_op_b};
        end else begin
            w_ea = {{IW{1'b0}}, w_op_a};
            w_eb = {{IW{1'b0}}, w_op_b};
        end
        w_prod = w_ea * w_eb;
    end

    generate
        if (LAT >= 3) begin : g_pdly
            logic [PW-1:0] r_pd [0:LAT-3];
            // Pure delay stages carrying the full product.
            always_ff @(posedge clk or posedge rst_b) begin
                if (rst_b) begin
                    for (int i = 0; i < LAT - 2; i++) begin
                        r_pd[i] <= '0;
                    end
                end else if (i_adv) begin
                    r_pd[0] <= w_prod;
                    for (int i = 1; i < LAT - 2; i++) begin
                        r_pd[i] <= r_pd[i-1];
                    end
                end
            end
            assign w_pfin = r_pd[LAT-3];
        end else begin : g_pdir
            assign w_pfin = w_prod;
        end
    endgenerate

    // Round (optional), shift to the window and detect overflow at 2*IW+1 bits.
    always_comb begin
        if (IS_SGN) begin
            w_pext = {w_pfin[PW-1], w_pfin};
        end else begin
            w_pext = {1'b0, w_pfin};
        end
`ifdef WL_MULT_ROUND_EN
        w_rnd = w_pext + RND_K;
`else
        w_rnd = w_pext;
`endif
        if (IS_SGN) begin
            w_win = $signed(w_rnd) >>> SHIFT;
            w_fit = (w_win[EW-1:OW-1] == {(EW-OW+1){w_win[EW-1]}});
        end else begin
            w_win = w_rnd >> SHIFT;
            w_fit = (w_win[EW-1:OW] == '0);
        end
        if (w_fit) begin
            w_res = w_win[OW-1:0];
            w_ovf = 1'b0;
        end else if (IS_SGN && w_win[EW-1]) begin
            w_res = SAT_LO;
            w_ovf = 1'b1;
        end else begin
            w_res = SAT_HI;
            w_ovf = 1'b1;
        end
    end

    // Final stage: registered lane result and overflow flag.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            o_p   <= '0;
            o_ovf <= 1'b0;
        end else if (i_adv) begin
            o_p   <= w_res;
            o_ovf <= w_ovf;
        end
    end

endmodule

// File: rtl/wl_mult_pipe.sv
// Multi-lane fixed-point multiplier with valid/ready handshake.
// All lanes share one valid pipeline; the whole pipe advances whenever
// the output register is empty or being drained, so a stalled consumer
// freezes every stage without losing products. Bubbles are kept.
// Optional rounding is enabled by defining WL_MULT_ROUND_EN.
module wl_mult_pipe
    import wl_pkg::*;
#(
    parameter int NCH    = 1,
    parameter int IW     = 8,
    parameter int OW     = 8,
    parameter int SHIFT  = 8,
    parameter int LAT    = 3,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*IW-1:0] in_a,
    input  logic [NCH*IW-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*OW-1:0] out_p,
    output logic [NCH-1:0]    out_ovf
);

    logic           w_adv;
    logic [LAT-1:0] r_vld;

    assign w_adv     = ~r_vld[LAT-1] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[LAT-1];

    // Valid pipeline: shifts one place on every advance.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid & w_adv;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_lane
            localparam int A_LO = lane_lo(k, IW);
            localparam int P_LO = lane_lo(k, OW);
            wl_mult_lane #(
                .IW     (IW),
                .OW     (OW),
                .SHIFT  (SHIFT),
                .LAT    (LAT),
                .SIGNED (SIGNED)
            ) u_lane (
                .clk   (clk),
                .rst_b (rst_b),
                .i_adv (w_adv),
                .i_a   (in_a[A_LO +: IW]),
                .i_b   (in_b[A_LO +: IW]),
                .o_p   (out_p[P_LO +: OW]),
                .o_ovf (out_ovf[k])
            );
        end
    endgenerate

endmodule
